// File: rtl/logic_probe_reader.sv
// Reads NUM_WORDS probe registers per measurement period and streams them
// out as a checksummed byte frame over a valid/ready link.
module logic_probe_reader #(
    parameter int TIMEOUT   = 15,
    parameter int NUM_WORDS = 5
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        interrupt,
    output logic [2:0]  address,
    output logic        data_request,
    input  logic [31:0] data,
    input  logic        data_ready,
    output logic        interrupt_clear,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        error,
    output logic [15:0] frames
);

    localparam int NB = 4 * NUM_WORDS + 3;
    localparam int BW = $clog2(NB);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
    localparam logic [2:0]    W_LAST = 3'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CLEAR,
        SEND
    } state_t;

    state_t          state;
    logic [2:0]      index;
    logic [TW-1:0]   wait_cnt;
    logic [BW-1:0]   byte_idx;
    logic [31:0]     buffer [8];
    logic [7:0]      checksum;
    logic [7:0]      next_byte;
    logic [BW-1:0]   nxt;
    logic [BW-1:0]   word_off;
    logic [31:0]     word;

    always_comb begin
        checksum = frames[7:0];
        for (int w = 0; w < NUM_WORDS; w++) begin
            checksum = checksum
                     ^ buffer[3'(w)][7:0]
                     ^ buffer[3'(w)][15:8]
                     ^ buffer[3'(w)][23:16]
                     ^ buffer[3'(w)][31:24];
        end
    end

    // Byte presented after the current one transfers
    always_comb begin
        nxt       = byte_idx + BW'(1);
        word_off  = nxt - BW'(2);
        word      = buffer[3'(word_off >> 2)];
        next_byte = 8'(word >> {word_off[1:0], 3'b000});
        if (nxt == BW'(1)) begin
            next_byte = frames[7:0];
        end else if (nxt == B_LAST) begin
            next_byte = checksum;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state           <= IDLE;
            index           <= '0;
            wait_cnt        <= '0;
            byte_idx        <= '0;
            address         <= '0;
            data_request    <= 1'b0;
            interrupt_clear <= 1'b0;
            tx_valid        <= 1'b0;
            tx_data         <= 8'h00;
            busy            <= 1'b0;
            error           <= 1'b0;
            frames          <= '0;
        end else begin
            data_request    <= 1'b0;
            interrupt_clear <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (interrupt && enable) begin
                        state        <= REQ;
                        index        <= '0;
                        address      <= '0;
                        data_request <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (data_ready || wait_cnt == T_LAST) begin
                        buffer[index] <= data_ready ? data : 32'hFFFF_FFFF;
                        if (!data_ready) begin
                            error <= 1'b1;
                        end
                        if (index == W_LAST) begin
                            state           <= CLEAR;
                            interrupt_clear <= 1'b1;
                        end else begin
                            state        <= REQ;
                            index        <= index + 3'd1;
                            address      <= index + 3'd1;
                            data_request <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                CLEAR: begin
                    state    <= SEND;
                    tx_valid <= 1'b1;
                    tx_data  <= 8'hA5;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == B_LAST) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            busy     <= 1'b0;
                            frames   <= frames + 16'd1;
                        end else begin
                            byte_idx <= nxt;
                            tx_data  <= next_byte;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_probe_reader.sv
// Self-checking bench for logic_probe_reader: probe and sink models plus a
// frame-level reference built from the captured words.
module tb_logic_probe_reader;

    localparam int TIMEOUT   = 15;
    localparam int NUM_WORDS = 5;
    localparam int NB        = 4 * NUM_WORDS + 3;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        enable = 1'b0;
    logic        interrupt = 1'b0;
    logic        data_ready = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] data = '0;
    logic [2:0]  address;
    logic        data_request;
    logic        interrupt_clear;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        error;
    logic [15:0] frames;

    always #5 clk = ~clk;

    logic_probe_reader #(
        .TIMEOUT   (TIMEOUT),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .enable          (enable),
        .interrupt       (interrupt),
        .address         (address),
        .data_request    (data_request),
        .data            (data),
        .data_ready      (data_ready),
        .interrupt_clear (interrupt_clear),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .error           (error),
        .frames          (frames)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem [8];
    int          silent_addr = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          stray_en = 1'b0;
    int          pend_periods = 0;
    int          rdy_mode = 0;
    int          stall_left = 0;
    logic [15:0] exp_frames = '0;

    logic [7:0]  rx [$];
    int          rx_t [$];
    int          req_addr [$];
    int          req_t [$];
    logic [7:0]  exp_q [$];
    int          clear_cnt = 0;
    int          hold_viol = 0;

    int          pend_cnt = 0;
    logic [2:0]  pend_addr = '0;
    bit          hold_prev = 1'b0;
    logic [7:0]  data_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Probe, interrupt source and byte sink, all acting on the falling edge
    always @(negedge clk) begin
        if (interrupt_clear === 1'b1) begin
            clear_cnt++;
            if (pend_periods > 0) pend_periods--;
            interrupt = 1'b0;
        end else begin
            interrupt = (pend_periods > 0);
        end

        data_ready = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                data_ready = 1'b1;
                data = mem[pend_addr];
            end
        end else if (stray_en && busy === 1'b0 && $urandom_range(3) == 0) begin
            data_ready = 1'b1;
            data = $urandom;
        end
        if (!data_ready) data = $urandom;
        if (data_request === 1'b1) begin
            req_addr.push_back(int'(address));
            req_t.push_back(cyc);
            if (int'(address) != silent_addr) begin
                pend_addr = address;
                pend_cnt = $urandom_range(lat_max, lat_min);
            end
        end

        if (hold_prev && (tx_valid !== 1'b1 || tx_data !== data_prev)) hold_viol++;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(1));
            default: begin
                if (tx_valid === 1'b1 && rx.size() == 7 && stall_left > 0) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        endcase
        if (tx_valid === 1'b1 && tx_ready) begin
            rx.push_back(tx_data);
            rx_t.push_back(cyc);
        end
        hold_prev = (tx_valid === 1'b1) && !tx_ready && (nreset === 1'b1);
        data_prev = tx_data;
    end

    task automatic add_frame(input logic [7:0] seq);
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        x = seq;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w = (i == silent_addr) ? 32'hFFFF_FFFF : mem[i];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(x);
    endtask

    function automatic int first_diff();
        if (rx.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (rx[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        rx.delete();
        rx_t.delete();
        req_addr.delete();
        req_t.delete();
        exp_q.delete();
        clear_cnt = 0;
        hold_viol = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx.size() >= exp_q.size() && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int d;
        @(negedge clk);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({address, data_request, interrupt_clear} !== 5'b0) begin
            failures++;
            $display("FAIL reset_probe_if: got addr=%0d req=%b clr=%b want 0 0 0",
                     address, data_request, interrupt_clear);
        end
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx: got valid=%b data=%h want 0 00", tx_valid, tx_data);
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b error=%b want 0 0", busy, error);
        end
        checks++;
        if (frames !== 16'h0) begin
            failures++;
            $display("FAIL reset_frames: got %h want 0000", frames);
        end
        exp_frames = '0;
        d = 0;
        nreset = 1'b1;
    endtask

    task automatic test_nominal();
        bit ok;
        bit seq_ok;
        int d;
        mem[0] = 32'h1111_2222;
        mem[1] = 32'h3333_4444;
        mem[2] = 32'h0000_0005;
        mem[3] = 32'h0000_0006;
        mem[4] = 32'h0000_0007;
        silent_addr = -1;
        lat_min = 1;
        lat_max = 1;
        rdy_mode = 0;
        enable = 1'b1;
        clear_logs();
        add_frame(exp_frames[7:0]);
        pend_periods = 1;
        wait_done(400, ok);
        exp_frames++;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL nominal_done: got rx=%0d bytes want %0d", rx.size(), exp_q.size());
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL nominal_frame: rx_len=%0d want %0d, byte %0d got %h want %h",
                     rx.size(), exp_q.size(), d,
                     (d >= 0) ? rx[d] : 8'h00, (d >= 0) ? exp_q[d] : 8'h00);
        end
        seq_ok = (req_addr.size() == NUM_WORDS);
        foreach (req_addr[i]) if (req_addr[i] != i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            failures++;
            $display("FAIL nominal_requests: got %0d strobes want one per address 0..%0d",
                     req_addr.size(), NUM_WORDS - 1);
        end
        checks++;
        if (clear_cnt != 1) begin
            failures++;
            $display("FAIL nominal_clear: got %0d clear cycles want 1", clear_cnt);
        end
        checks++;
        if (frames !== exp_frames || error !== 1'b0) begin
            failures++;
            $display("FAIL nominal_counters: got frames=%0d error=%b want %0d 0",
                     frames, error, exp_frames);
        end
        checks++;
        if (rx_t.size() != NB || rx_t[rx_t.size()-1] - rx_t[0] != NB - 1) begin
            failures++;
            $display("FAIL nominal_no_bubbles: got %0d bytes span %0d want %0d span %0d",
                     rx_t.size(), (rx_t.size() > 0) ? rx_t[rx_t.size()-1] - rx_t[0] : -1,
                     NB, NB - 1);
        end
    endtask

    task automatic test_enable_gating();
        bit ok;
        int d;
        enable = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
        clear_logs();
        pend_periods = 1;
        repeat (20) @(negedge clk);
        checks++;
        if (req_addr.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_block: got strobes=%0d busy=%b want 0 0",
                     req_addr.size(), busy);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (data_request !== 1'b1 || address !== 3'd0) begin
            failures++;
            $display("FAIL enable_latency: got req=%b addr=%0d want 1 0",
                     data_request, address);
        end
        add_frame(exp_frames[7:0]);
        wait_done(400, ok);
        exp_frames++;
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            failures++;
            $display("FAIL enable_frame: done=%b rx_len=%0d want %0d diff_at=%0d",
                     ok, rx.size(), exp_q.size(), d);
        end
        checks++;
        if (frames !== exp_frames) begin
            failures++;
            $display("FAIL enable_frames: got %0d want %0d", frames, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int d;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
        lat_min = 1;
        lat_max = 4;
        rdy_mode = 2;
        stall_left = 3;
        clear_logs();
        add_frame(exp_frames[7:0]);
        pend_periods = 1;
        wait_done(400, ok);
        exp_frames++;
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            failures++;
            $display("FAIL bp_frame: done=%b rx_len=%0d want %0d diff_at=%0d",
                     ok, rx.size(), exp_q.size(), d);
        end
        checks++;
        if (hold_viol != 0 || stall_left != 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d unstable cycles, %0d stalls unused, want 0 0",
                     hold_viol, stall_left);
        end
        checks++;
        if (rx_t.size() != NB || rx_t[rx_t.size()-1] - rx_t[0] != NB + 2) begin
            failures++;
            $display("FAIL bp_span: got %0d bytes span %0d want %0d span %0d",
                     rx_t.size(), (rx_t.size() > 0) ? rx_t[rx_t.size()-1] - rx_t[0] : -1,
                     NB, NB + 2);
        end
        rdy_mode = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        int d;
        int gap;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
        lat_min = 1;
        lat_max = 1;
        silent_addr = 2;
        clear_logs();
        add_frame(exp_frames[7:0]);
        pend_periods = 1;
        wait_done(600, ok);
        exp_frames++;
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            failures++;
            $display("FAIL timeout_frame: done=%b rx_len=%0d want %0d diff_at=%0d",
                     ok, rx.size(), exp_q.size(), d);
        end
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_error: got %b want 1", error);
        end
        gap = (req_t.size() >= 4) ? req_t[3] - req_t[2] : -1;
        checks++;
        if (gap != TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_wait_len: got strobe gap %0d want %0d", gap, TIMEOUT + 1);
        end
        silent_addr = -1;
        clear_logs();
        add_frame(exp_frames[7:0]);
        pend_periods = 1;
        wait_done(400, ok);
        exp_frames++;
        d = first_diff();
        checks++;
        if (!ok || d != -1 || error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: done=%b diff_at=%0d error=%b want 1 -1 1",
                     ok, d, error);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        bit hit;
        int d;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
        clear_logs();
        add_frame(exp_frames[7:0]);
        pend_periods = 1;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx.size() >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_mid_reach: got %0d bytes want 10", rx.size());
        end
        nreset = 1'b0;
        @(negedge clk);
        checks++;
        if ({address, data_request, interrupt_clear, tx_valid} !== 6'b0
            || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_outputs: addr=%0d req=%b clr=%b valid=%b data=%h want zeros",
                     address, data_request, interrupt_clear, tx_valid, tx_data);
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || frames !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_state: busy=%b error=%b frames=%0d want 0 0 0",
                     busy, error, frames);
        end
        exp_frames = '0;
        nreset = 1'b1;
        @(negedge clk);
        clear_logs();
        add_frame(exp_frames[7:0]);
        pend_periods = 1;
        wait_done(400, ok);
        exp_frames++;
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            failures++;
            $display("FAIL rst_mid_next_frame: done=%b rx_len=%0d want %0d diff_at=%0d",
                     ok, rx.size(), exp_q.size(), d);
        end
        checks++;
        if (frames !== exp_frames) begin
            failures++;
            $display("FAIL rst_mid_frames: got %0d want %0d", frames, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        @(negedge clk);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        exp_frames = '0;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
        lat_min = 1;
        lat_max = 6;
        rdy_mode = 1;
        stray_en = 1'b1;
        clear_logs();
        for (int k = 0; k < 3; k++) add_frame(8'(k));
        pend_periods = 3;
        wait_done(3000, ok);
        exp_frames = exp_frames + 16'd3;
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            failures++;
            $display("FAIL b2b_frames: done=%b rx_len=%0d want %0d diff_at=%0d",
                     ok, rx.size(), exp_q.size(), d);
        end
        checks++;
        if (frames !== 16'd3) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 3", frames);
        end
        checks++;
        if (clear_cnt != 3 || req_addr.size() != 3 * NUM_WORDS) begin
            failures++;
            $display("FAIL b2b_strobes: got clears=%0d reqs=%0d want 3 %0d",
                     clear_cnt, req_addr.size(), 3 * NUM_WORDS);
        end
        checks++;
        if (hold_viol != 0 || error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold: got unstable=%0d error=%b want 0 0", hold_viol, error);
        end
        stray_en = 1'b0;
        rdy_mode = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_nominal();
        test_enable_gating();
        test_backpressure();
        test_timeout();
        test_reset_mid_send();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_probe_reader.md
LOGIC_PROBE_READER -- requirements
Module: logic_probe_reader

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles WAIT holds for data_ready before the word is declared missing.
REQ-002 Parameter NUM_WORDS, default 5: number of probe registers read per acquisition (addresses 0..NUM_WORDS-1).
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 nreset  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  permits starting a new acquisition.
REQ-006 interrupt  in  1  probe measurement-period-complete flag; held high until cleared.
REQ-007 address  out  3  probe register select.
REQ-008 data_request  out  1  one-cycle read strobe to the probe.
REQ-009 data  in  32  probe read data, valid when data_ready=1.
REQ-010 data_ready  in  1  probe read acknowledge.
REQ-011 interrupt_clear  out  1  one-cycle pulse that restarts the probe period.
REQ-012 tx_data  out  8  output byte stream.
REQ-013 tx_valid  out  1  tx_data valid.
REQ-014 tx_ready  in  1  sink accepts the byte; a transfer occurs on a posedge with tx_valid=1 and tx_ready=1.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 error  out  1  sticky flag: at least one read timed out since reset.
REQ-017 frames  out  16  completed-frame counter.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, CLEAR, SEND.
REQ-019 IDLE: when interrupt=1 and enable=1, go to REQ with word index=0; otherwise stay in IDLE.
REQ-020 REQ: data_request=1 for exactly one cycle, address=index, then go to WAIT.
REQ-021 address SHALL hold the current index through REQ and WAIT.
REQ-022 data_request SHALL rise in the cycle after IDLE samples interrupt=1 and enable=1.
REQ-023 WAIT, data_ready=1: capture data into buffer[index]; go to REQ with index+1 if index<NUM_WORDS-1, else go to CLEAR.
REQ-024 WAIT timeout: if data_ready stays low for TIMEOUT cycles, store 0xFFFFFFFF in buffer[index], set error, and advance as in REQ-023.
REQ-025 A data_ready outside WAIT SHALL be ignored.
REQ-026 CLEAR: interrupt_clear=1 for exactly one cycle, then go to SEND.
REQ-027 SEND frame, 2+4*NUM_WORDS+1 bytes (23 by default), in this order:
- 0xA5;
- frames[7:0];
- buffer[0..NUM_WORDS-1], each little-endian;
- checksum = XOR of all bytes after 0xA5.
REQ-028 Handshake: tx_valid stays asserted throughout the frame; tx_data is stable while tx_valid=1 and tx_ready=0; the next byte is presented in the cycle after each transfer.
REQ-029 No bubbles: tx_ready held high SHALL move one byte per cycle.
REQ-030 After the last byte transfers, tx_valid=0, frames increments (wraps 0xFFFF->0x0000), and state returns to IDLE.
REQ-031 interrupt changes during REQ, WAIT, CLEAR or SEND SHALL be ignored; a still-high interrupt in IDLE starts the next acquisition (no lost periods).
REQ-032 enable=0 mid-acquisition SHALL NOT abort the acquisition; it only blocks leaving IDLE.

Reset
REQ-033 While nreset=0 at posedge:
- state=IDLE, index=0;
- address=0, data_request=0, interrupt_clear=0;
- tx_valid=0, tx_data=0x00;
- busy=0, error=0, frames=0.
REQ-034 Reset SHALL win over any simultaneous event; a frame interrupted by reset is abandoned and never resumed.

Verification
REQ-035 Nominal read: probe model with 1-cycle data_ready returns 0x11112222, 0x33334444, 0x00000005, 0x00000006, 0x00000007; interrupt=1, tx_ready=1 -> one data_request pulse per address 0..4; one interrupt_clear pulse; bytes A5 00 22 22 11 11 44 44 33 33 05 00 00 00 06 00 00 00 07 00 00 00 checksum; frames=1.
REQ-036 Backpressure: tx_ready low 3 cycles at byte 7 -> tx_data/tx_valid stable, 23 bytes total, no byte dropped or duplicated.
REQ-037 Timeout: probe silent on address 2 -> after 15 cycles, word2 bytes FF FF FF FF; error=1 and stays 1; frame still completes.
REQ-038 Reset during SEND byte 10 -> next cycle all outputs at reset values; the next acquisition sends seq byte 00.
REQ-039 Enable gating: enable=0 with interrupt=1 for 20 cycles -> no data_request, busy=0; enable rises -> data_request one cycle later.
REQ-040 Sequence: three back-to-back acquisitions -> seq bytes 00, 01, 02; frames=3.
